// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with open-collector line control.
// Define PS2_TX_GLITCH_FILTER_EN to add an 8-sample stable filter on PS2_CLK.
`timescale 1ns/1ps
module ps2_host_tx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_US = 15000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int CYC_US      = CLK_FREQ / 1000000;
    localparam int INHIBIT_CYC = INHIBIT_US * CYC_US;
    localparam int TIMEOUT_CYC = TIMEOUT_US * CYC_US;
    localparam int MAX_A       = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int MAX_CYC     = (MAX_A > CYC_US) ? MAX_A : CYC_US;
    localparam int CW          = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYC - 1);
    localparam logic [CW-1:0] REQ_LAST     = CW'(CYC_US - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    bitcnt;
    logic [9:0]    frame;
    logic          nack;

    logic clk_s1, clk_s2;
    logic data_s1, data_s2;
    logic clk_edge_src;
    logic clk_prev;
    logic fall;
    logic timed_out;

    // Lines idle high, so the synchronizers reset to 1 to avoid a false fall.
    always_ff @(posedge clk) begin
        if (clr) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk_in;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data_in;
            data_s2 <= data_s1;
        end
    end

`ifdef PS2_TX_GLITCH_FILTER_EN
    logic [2:0] filt_cnt;
    logic       clk_filt;

    always_ff @(posedge clk) begin
        if (clr) begin
            filt_cnt <= 3'd0;
            clk_filt <= 1'b1;
        end else if (clk_s2 == clk_filt) begin
            filt_cnt <= 3'd0;
        end else if (filt_cnt == 3'd7) begin
            filt_cnt <= 3'd0;
            clk_filt <= clk_s2;
        end else begin
            filt_cnt <= filt_cnt + 3'd1;
        end
    end

    assign clk_edge_src = clk_filt;
`else
    assign clk_edge_src = clk_s2;
`endif

    always_ff @(posedge clk) begin
        if (clr) clk_prev <= 1'b1;
        else     clk_prev <= clk_edge_src;
    end

    assign fall = clk_prev & ~clk_edge_src;

    assign timed_out = ((state == SEND) || (state == ACK) || (state == WAIT_IDLE))
                       && (cnt == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= IDLE;
            tx_ready    <= 1'b1;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            cnt         <= '0;
            bitcnt      <= 4'd0;
            frame       <= 10'd0;
            nack        <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            if (timed_out) begin
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                tx_done     <= 1'b1;
                tx_err      <= 1'b1;
                state       <= DONE;
            end else begin
                case (state)
                    IDLE: begin
                        if (tx_valid) begin
                            frame      <= {1'b1, ~^tx_data, tx_data};
                            tx_ready   <= 1'b0;
                            busy       <= 1'b1;
                            ps2_clk_oe <= 1'b1;
                            cnt        <= '0;
                            nack       <= 1'b0;
                            state      <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (cnt == INHIBIT_LAST) begin
                            cnt         <= '0;
                            ps2_data_oe <= 1'b1;
                            state       <= REQ;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    REQ: begin
                        if (cnt == REQ_LAST) begin
                            cnt        <= '0;
                            bitcnt     <= 4'd0;
                            ps2_clk_oe <= 1'b0;
                            state      <= SEND;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    SEND: begin
                        cnt <= cnt + 1'b1;
                        if (fall) begin
                            ps2_data_oe <= ~frame[bitcnt];
                            bitcnt      <= bitcnt + 4'd1;
                            if (bitcnt == 4'd9) state <= ACK;
                        end
                    end
                    ACK: begin
                        cnt <= cnt + 1'b1;
                        if (fall) begin
                            nack  <= data_s2;
                            state <= WAIT_IDLE;
                        end
                    end
                    WAIT_IDLE: begin
                        cnt <= cnt + 1'b1;
                        if (clk_s2 && data_s2) begin
                            tx_done <= 1'b1;
                            tx_err  <= nack;
                            state   <= DONE;
                        end
                    end
                    DONE: begin
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-collector PS/2 device model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       tx_done;
    logic       tx_err;

    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;
    logic dev_active = 1'b0;
    logic mon_clr = 1'b0;
    logic mon_en = 1'b0;

    int tests = 0;
    int fails = 0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .CLK_FREQ  (1000000),
        .INHIBIT_US(100),
        .TIMEOUT_US(2000)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err)
    );

    always #5 clk = ~clk;

    int   inh_cyc, req_cyc, send_cyc, done_cnt, clk_bad, busy_bad;
    logic seen_req, done_err, done_busy, ready_after, prev_done;
    logic [1:0] done_oe;

    always @(negedge clk) begin
        if (mon_clr) begin
            inh_cyc     <= 0;
            req_cyc     <= 0;
            send_cyc    <= 0;
            done_cnt    <= 0;
            clk_bad     <= 0;
            busy_bad    <= 0;
            seen_req    <= 1'b0;
            done_err    <= 1'b0;
            done_busy   <= 1'b0;
            ready_after <= 1'b0;
            prev_done   <= 1'b0;
            done_oe     <= 2'b00;
        end else begin
            prev_done <= tx_done;
            if (prev_done) ready_after <= tx_ready;
            if (ps2_clk_oe && !ps2_data_oe) inh_cyc <= inh_cyc + 1;
            if (ps2_clk_oe && ps2_data_oe) begin
                req_cyc  <= req_cyc + 1;
                seen_req <= 1'b1;
            end
            if (seen_req && !ps2_clk_oe && busy && !tx_done) send_cyc <= send_cyc + 1;
            if (tx_done) begin
                done_cnt  <= done_cnt + 1;
                done_err  <= tx_err;
                done_busy <= busy;
                done_oe   <= {ps2_clk_oe, ps2_data_oe};
            end
            if (dev_active && ps2_clk_oe) clk_bad <= clk_bad + 1;
            if (mon_en && (busy === tx_ready)) busy_bad <= busy_bad + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        @(negedge clk);
        #2 mon_clr = 1'b1;
        @(negedge clk);
        #2 mon_clr = 1'b0;
    endtask

    task automatic accept(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        #1;
        chk("accept_busy", busy, 1'b1);
        chk("accept_ready", tx_ready, 1'b0);
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!ps2_clk_oe && ps2_data_oe) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Device clocks at 10 kHz (100 system cycles) and reads data mid-low.
    task automatic device(input bit ack, input bit glitch,
                          output logic [9:0] bits, output bit ok);
        bits = 10'd0;
        wait_req(ok);
        if (!ok) return;
        dev_active = 1'b1;
        repeat (10) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11) begin
                dev_data_low = ack;
                repeat (10) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (25) @(negedge clk);
            if (k <= 10) bits[k-1] = ps2_data_in;
            repeat (25) @(negedge clk);
            dev_clk_low  = 1'b0;
            if (k == 11) begin
                dev_data_low = 1'b0;
            end else if (glitch) begin
                repeat (20) @(negedge clk);
                dev_clk_low = 1'b1;
                repeat (3) @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (27) @(negedge clk);
            end else begin
                repeat (50) @(negedge clk);
            end
        end
        dev_active = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    logic [9:0] bits;
    bit         ok;

    initial begin
        repeat (3) @(negedge clk);
        clr = 1'b0;
        #1;
        chk("rst_ready", tx_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_clk_oe", ps2_clk_oe, 1'b0);
        chk("rst_data_oe", ps2_data_oe, 1'b0);
        chk("rst_done", tx_done, 1'b0);
        chk("rst_err", tx_err, 1'b0);
        mon_en = 1'b1;

        // 0xED, acknowledged
        clear_mon();
        accept(8'hED);
        device(1'b1, 1'b0, bits, ok);
        chk("ed_req_seen", ok, 1'b1);
        chk("ed_frame", bits, 10'h3ED);
        wait_done(500, ok);
        chk("ed_done_seen", ok, 1'b1);
        chk("ed_inhibit_cyc", inh_cyc, 100);
        chk("ed_req_cyc", req_cyc, 1);
        chk("ed_done_cnt", done_cnt, 1);
        chk("ed_err", done_err, 1'b0);
        chk("ed_ready_after", ready_after, 1'b1);
        chk("ed_clk_released", clk_bad, 0);

        // 0xF4, acknowledged, busy coverage
        clear_mon();
        accept(8'hF4);
        device(1'b1, 1'b0, bits, ok);
        chk("f4_req_seen", ok, 1'b1);
        chk("f4_frame", bits, 10'h2F4);
        wait_done(500, ok);
        chk("f4_done_seen", ok, 1'b1);
        chk("f4_busy_at_done", done_busy, 1'b1);
        chk("f4_busy_vs_ready", busy_bad, 0);
        chk("f4_err", done_err, 1'b0);

        // 0x00, device NACKs
        clear_mon();
        accept(8'h00);
        device(1'b0, 1'b0, bits, ok);
        chk("00_frame", bits, 10'h300);
        wait_done(500, ok);
        chk("00_done_seen", ok, 1'b1);
        chk("00_done_cnt", done_cnt, 1);
        chk("00_err", done_err, 1'b1);

        // 0xFF, device silent -> timeout
        clear_mon();
        accept(8'hFF);
        wait_done(3000, ok);
        chk("ff_done_seen", ok, 1'b1);
        chk("ff_send_cyc", send_cyc, 2000);
        chk("ff_err", done_err, 1'b1);
        chk("ff_oe_at_done", done_oe, 2'b00);
        chk("ff_ready_after", ready_after, 1'b1);

        // Request while busy, then reset mid-SEND
        clear_mon();
        accept(8'h12);
        wait_req(ok);
        chk("rs_req_seen", ok, 1'b1);
        for (int k = 0; k < 3; k++) begin
            dev_clk_low = 1'b1;
            repeat (50) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (50) @(negedge clk);
        end
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("rs_busy_hold", busy, 1'b1);
        chk("rs_ready_low", tx_ready, 1'b0);
        chk("rs_no_done", done_cnt, 0);
        clr      = 1'b1;
        tx_valid = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("rs_clk_oe", ps2_clk_oe, 1'b0);
        chk("rs_data_oe", ps2_data_oe, 1'b0);
        chk("rs_ready", tx_ready, 1'b1);
        chk("rs_done", tx_done, 1'b0);
        chk("rs_busy", busy, 1'b0);
        clear_mon();
        repeat (200) @(negedge clk);
        #1;
        chk("rs_no_restart", inh_cyc, 0);

`ifdef PS2_TX_GLITCH_FILTER_EN
        clear_mon();
        accept(8'hED);
        device(1'b1, 1'b1, bits, ok);
        chk("gf_frame", bits, 10'h3ED);
        wait_done(500, ok);
        chk("gf_done_seen", ok, 1'b1);
        chk("gf_err", done_err, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
